// File: rtl/word_unpacker.sv
// Width down-converter: IN_W-bit words through a DEPTH-word FIFO out as R = IN_W/OUT_W slices.
// Define UNPACK_LSB_FIRST_EN to emit the least significant slice first (MSB-first by default).
module word_unpacker #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             valid_in,
  input  logic [IN_W-1:0]  data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [OUT_W-1:0] data_out,
  output logic             last_out,
  input  logic             ready_out,
  output logic             idle
);

  localparam int R     = IN_W / OUT_W;
  localparam int IDX_W = $clog2(R);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(R - 1);

  typedef enum logic {
    SH_EMPTY = 1'b0,
    SH_BUSY  = 1'b1
  } sh_state_e;

  logic [IN_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  sh_state_e        state_q;
  logic [IN_W-1:0]  shreg_q;
  logic [IDX_W-1:0] slice_idx_q;

  logic push;
  logic pop;
  logic fifo_nonempty;
  logic last_slice;

  assign fifo_nonempty = (count_q != '0);
  assign last_slice    = (slice_idx_q == LAST_IDX);

  // ready_in depends only on the occupancy register, never on ready_out or valid_in.
  assign ready_in = reset_L & (count_q < CNT_W'(DEPTH));
  assign push     = valid_in & ready_in;
  assign pop      = fifo_nonempty &
                    ((state_q == SH_EMPTY) |
                     ((state_q == SH_BUSY) & ready_out & last_slice));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // The outgoing slice always sits at one end of shreg_q; consumed slices shift out.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= SH_EMPTY;
      shreg_q     <= '0;
      slice_idx_q <= '0;
    end else begin
      case (state_q)
        SH_EMPTY: begin
          if (pop) begin
            shreg_q     <= mem_q[rd_ptr_q];
            slice_idx_q <= '0;
            state_q     <= SH_BUSY;
          end
        end
        SH_BUSY: begin
          if (ready_out) begin
            if (!last_slice) begin
`ifdef UNPACK_LSB_FIRST_EN
              shreg_q <= shreg_q >> OUT_W;
`else
              shreg_q <= shreg_q << OUT_W;
`endif
              slice_idx_q <= slice_idx_q + IDX_W'(1);
            end else if (fifo_nonempty) begin
              shreg_q     <= mem_q[rd_ptr_q];
              slice_idx_q <= '0;
            end else begin
              shreg_q     <= '0;
              slice_idx_q <= '0;
              state_q     <= SH_EMPTY;
            end
          end
        end
        default: begin
          state_q     <= SH_EMPTY;
          shreg_q     <= '0;
          slice_idx_q <= '0;
        end
      endcase
    end
  end

`ifdef UNPACK_LSB_FIRST_EN
  assign data_out = shreg_q[OUT_W-1:0];
`else
  assign data_out = shreg_q[IN_W-1 -: OUT_W];
`endif

  assign valid_out = (state_q == SH_BUSY);
  assign last_out  = valid_out & last_slice;
  assign idle      = ~fifo_nonempty & (state_q == SH_EMPTY);

endmodule
